// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> sequencer bundle: decode/hazard info in, stage controls and selects out.
interface pipeline_ctrl_if;
  // IF / ID information
  logic [31:0] inst_addr;
  logic        is_jump;
  logic        is_jr;
  logic        is_beq;
  logic        is_bne;
  logic        rs_used;
  logic        rt_used;
  logic        rs_rt_equal;
  logic [4:0]  addr_rs;
  logic [4:0]  addr_rt;
  // EXE stage
  logic [4:0]  regw_addr_exe;
  logic        wb_wen_exe;
  logic        is_load_exe;
  // MEM stage
  logic [4:0]  regw_addr_mem;
  logic        wb_wen_mem;
  logic        is_load_mem;
  logic [4:0]  rt_addr_mem;
  logic        is_store_mem;
  // WB stage
  logic [4:0]  regw_addr_wb;
  logic        wb_wen_wb;
  // Stage controls and selects
  logic        if_rst;
  logic        if_en;
  logic        id_rst;
  logic        id_en;
  logic        exe_rst;
  logic        exe_en;
  logic        mem_rst;
  logic        mem_en;
  logic        wb_rst;
  logic        wb_en;
  logic [1:0]  pc_src;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        fwd_mem;

  // Datapath side
  modport master (
    output inst_addr, is_jump, is_jr, is_beq, is_bne, rs_used, rt_used, rs_rt_equal,
           addr_rs, addr_rt, regw_addr_exe, wb_wen_exe, is_load_exe,
           regw_addr_mem, wb_wen_mem, is_load_mem, rt_addr_mem, is_store_mem,
           regw_addr_wb, wb_wen_wb,
    input  if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en,
           pc_src, fwd_a, fwd_b, fwd_mem
  );

  // Sequencer side
  modport slave (
    input  inst_addr, is_jump, is_jr, is_beq, is_bne, rs_used, rt_used, rs_rt_equal,
           addr_rs, addr_rt, regw_addr_exe, wb_wen_exe, is_load_exe,
           regw_addr_mem, wb_wen_mem, is_load_mem, rt_addr_mem, is_store_mem,
           regw_addr_wb, wb_wen_wb,
    output if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en,
           pc_src, fwd_a, fwd_b, fwd_mem
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline sequencer: run control (halt/run/step/breakpoint), hazard
// handling, PC source, forwarding selects and stall/flush counters.
module pipeline_ctrl #(
  parameter bit          BP_ENABLE = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              step,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  pipeline_ctrl_if.slave    dp,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;
  localparam logic [1:0] PC_JR     = 2'd3;

  typedef enum logic [1:0] {S_HALT = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2} state_t;

  state_t state;
  logic   step_q;
  logic   resume_q;   // first RUN cycle after HALT: ignore the breakpoint
  logic   step_rise;
  logic   bp_hit;
  logic   active;
  logic   load_stall;
  logic   taken;

  assign step_rise = step & ~step_q;
  assign bp_hit    = BP_ENABLE && bp_en && (dp.inst_addr == bp_addr) && !resume_q;
  assign active    = (state == S_RUN) || (state == S_STEP);
  assign halted    = (state == S_HALT);

  // Load-use hazard against the instruction in ID
  assign load_stall = dp.is_load_exe && dp.wb_wen_exe && (dp.regw_addr_exe != 5'd0) &&
                      ((dp.rs_used && (dp.regw_addr_exe == dp.addr_rs)) ||
                       (dp.rt_used && (dp.regw_addr_exe == dp.addr_rt)));

  assign taken = dp.is_jump || dp.is_jr || (dp.is_beq && dp.rs_rt_equal) ||
                 (dp.is_bne && !dp.rs_rt_equal);

  // Run-control FSM, step edge detect and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HALT;
      step_q    <= 1'b0;
      resume_q  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      step_q   <= step;
      resume_q <= 1'b0;
      case (state)
        S_HALT: begin
          if (cpu_en) begin
            state    <= S_RUN;
            resume_q <= 1'b1;
          end else if (step_rise) begin
            state <= S_STEP;
          end
        end
        S_RUN:   if (!cpu_en || bp_hit) state <= S_HALT;
        S_STEP:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
      if (active && load_stall)
        stall_cnt <= stall_cnt + CNT_W'(1);
      else if (active && taken)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Stage enables/resets and PC source for the current cycle
  always_comb begin
    dp.if_rst  = 1'b0;
    dp.if_en   = 1'b0;
    dp.id_rst  = 1'b0;
    dp.id_en   = 1'b0;
    dp.exe_rst = 1'b0;
    dp.exe_en  = 1'b0;
    dp.mem_rst = 1'b0;
    dp.mem_en  = 1'b0;
    dp.wb_rst  = 1'b0;
    dp.wb_en   = 1'b0;
    dp.pc_src  = PC_NEXT;
    if (rst) begin
      dp.if_rst  = 1'b1;
      dp.id_rst  = 1'b1;
      dp.exe_rst = 1'b1;
      dp.mem_rst = 1'b1;
      dp.wb_rst  = 1'b1;
    end else if (active) begin
      if (load_stall) begin
        // Hold IF/ID, bubble into EXE, let older instructions drain
        dp.exe_rst = 1'b1;
        dp.exe_en  = 1'b1;
        dp.mem_en  = 1'b1;
        dp.wb_en   = 1'b1;
      end else begin
        dp.if_en  = 1'b1;
        dp.id_en  = 1'b1;
        dp.exe_en = 1'b1;
        dp.mem_en = 1'b1;
        dp.wb_en  = 1'b1;
        dp.id_rst = taken;
        if (dp.is_jr)       dp.pc_src = PC_JR;
        else if (dp.is_jump) dp.pc_src = PC_JUMP;
        else if (taken)      dp.pc_src = PC_BRANCH;
      end
    end
  end

  // Operand forwarding: EXE ALU result first, then MEM (ALU or load data)
  always_comb begin
    dp.fwd_a   = 2'd0;
    dp.fwd_b   = 2'd0;
    dp.fwd_mem = 1'b0;
    if (!rst) begin
      if (dp.addr_rs != 5'd0) begin
        if (dp.wb_wen_exe && !dp.is_load_exe && (dp.regw_addr_exe == dp.addr_rs))
          dp.fwd_a = 2'd1;
        else if (dp.wb_wen_mem && (dp.regw_addr_mem == dp.addr_rs))
          dp.fwd_a = dp.is_load_mem ? 2'd3 : 2'd2;
      end
      if (dp.addr_rt != 5'd0) begin
        if (dp.wb_wen_exe && !dp.is_load_exe && (dp.regw_addr_exe == dp.addr_rt))
          dp.fwd_b = 2'd1;
        else if (dp.wb_wen_mem && (dp.regw_addr_mem == dp.addr_rt))
          dp.fwd_b = dp.is_load_mem ? 2'd3 : 2'd2;
      end
      dp.fwd_mem = dp.is_store_mem && dp.wb_wen_wb && (dp.regw_addr_wb != 5'd0) &&
                   (dp.regw_addr_wb == dp.rt_addr_mem);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for hazard/forwarding/PC logic
// plus hand sequences for reset, breakpoint, single-step and reset-during-stall.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic        step;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic        halted;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.BP_ENABLE(1'b1), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_en    (cpu_en),
    .step      (step),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .dp        (bus),
    .halted    (halted),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  typedef struct {
    string      name;
    logic       jump, jr, beq, bne, rs_used, rt_used, eq;
    logic [4:0] rs, rt;
    logic [4:0] ea; logic ew, el;
    logic [4:0] ma; logic mw, ml;
    logic [4:0] sa; logic st;
    logic [4:0] wa; logic ww;
    logic [4:0] exp_en;   // {if,id,exe,mem,wb}
    logic [4:0] exp_rst;  // {if,id,exe,mem,wb}
    logic [1:0] exp_pc, exp_fa, exp_fb;
    logic       exp_fm;
  } row_t;

  row_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  int   act_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic row_t clr(input string name);
    row_t r;
    r.name = name;
    {r.jump, r.jr, r.beq, r.bne, r.rs_used, r.rt_used, r.eq} = '0;
    r.rs = '0; r.rt = '0;
    r.ea = '0; r.ew = 1'b0; r.el = 1'b0;
    r.ma = '0; r.mw = 1'b0; r.ml = 1'b0;
    r.sa = '0; r.st = 1'b0;
    r.wa = '0; r.ww = 1'b0;
    r.exp_en = 5'b11111; r.exp_rst = 5'b00000;
    r.exp_pc = 2'd0; r.exp_fa = 2'd0; r.exp_fb = 2'd0; r.exp_fm = 1'b0;
    return r;
  endfunction

  task automatic apply(input row_t r);
    bus.is_jump = r.jump;   bus.is_jr = r.jr;   bus.is_beq = r.beq; bus.is_bne = r.bne;
    bus.rs_used = r.rs_used; bus.rt_used = r.rt_used; bus.rs_rt_equal = r.eq;
    bus.addr_rs = r.rs; bus.addr_rt = r.rt;
    bus.regw_addr_exe = r.ea; bus.wb_wen_exe = r.ew; bus.is_load_exe = r.el;
    bus.regw_addr_mem = r.ma; bus.wb_wen_mem = r.mw; bus.is_load_mem = r.ml;
    bus.rt_addr_mem = r.sa; bus.is_store_mem = r.st;
    bus.regw_addr_wb = r.wa; bus.wb_wen_wb = r.ww;
  endtask

  function automatic logic [4:0] en_v();
    return {bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en};
  endfunction

  function automatic logic [4:0] rst_v();
    return {bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst};
  endfunction

  task automatic build_vectors();
    row_t r;
    r = clr("idle");                                                          vecs.push_back(r);
    r = clr("lw_use_rs"); r.el = 1; r.ew = 1; r.ea = 1; r.rs_used = 1; r.rs = 1;
    r.exp_en = 5'b00111; r.exp_rst = 5'b00100;                                vecs.push_back(r);
    r = clr("fwd_a_load_mem"); r.ma = 1; r.mw = 1; r.ml = 1; r.rs_used = 1; r.rs = 1;
    r.exp_fa = 2'd3;                                                          vecs.push_back(r);
    r = clr("beq_taken"); r.beq = 1; r.eq = 1; r.exp_pc = 2'd2; r.exp_rst = 5'b01000; vecs.push_back(r);
    r = clr("beq_not_taken"); r.beq = 1; r.eq = 0;                            vecs.push_back(r);
    r = clr("bne_taken"); r.bne = 1; r.eq = 0; r.exp_pc = 2'd2; r.exp_rst = 5'b01000; vecs.push_back(r);
    r = clr("jump"); r.jump = 1; r.exp_pc = 2'd1; r.exp_rst = 5'b01000;       vecs.push_back(r);
    r = clr("jr_over_jump"); r.jr = 1; r.jump = 1; r.exp_pc = 2'd3; r.exp_rst = 5'b01000; vecs.push_back(r);
    r = clr("fwd_b_exe_prio"); r.ea = 5; r.ew = 1; r.ma = 5; r.mw = 1; r.ml = 1;
    r.rt_used = 1; r.rt = 5; r.exp_fb = 2'd1;                                 vecs.push_back(r);
    r = clr("fwd_reg0"); r.ea = 0; r.ew = 1; r.ma = 0; r.mw = 1; r.ml = 1;
    r.rt_used = 1; r.rt = 0; r.rs = 0;                                        vecs.push_back(r);
    r = clr("fwd_mem_alu"); r.ma = 7; r.mw = 1; r.rs = 7; r.rt = 7;
    r.exp_fa = 2'd2; r.exp_fb = 2'd2;                                         vecs.push_back(r);
    r = clr("load_no_use"); r.el = 1; r.ew = 1; r.ea = 1; r.rs = 1;           vecs.push_back(r);
    r = clr("stall_beats_beq"); r.el = 1; r.ew = 1; r.ea = 2; r.rt_used = 1; r.rt = 2;
    r.beq = 1; r.eq = 1; r.exp_en = 5'b00111; r.exp_rst = 5'b00100;           vecs.push_back(r);
    r = clr("fwd_store"); r.st = 1; r.sa = 4; r.ww = 1; r.wa = 4; r.exp_fm = 1; vecs.push_back(r);
    r = clr("fwd_store_reg0"); r.st = 1; r.sa = 0; r.ww = 1; r.wa = 0;        vecs.push_back(r);
    r = clr("exe_no_wen"); r.ea = 3; r.ew = 0; r.ma = 3; r.mw = 1; r.rs = 3;
    r.exp_fa = 2'd2;                                                          vecs.push_back(r);
    r = clr("load_to_reg0"); r.el = 1; r.ew = 1; r.ea = 0; r.rs_used = 1; r.rs = 0; vecs.push_back(r);
    r = clr("bne_not_taken"); r.bne = 1; r.eq = 1;                            vecs.push_back(r);
  endtask

  initial begin
    row_t st_row;
    rst = 1'b1; cpu_en = 1'b1; step = 1'b0; bp_en = 1'b0; bp_addr = 32'h0;
    bus.inst_addr = 32'h100;
    apply(clr("init"));
    build_vectors();

    // Reset: three cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_halted", 32'(halted), 32'd1);
    chk("reset_rst", 32'(rst_v()), 32'h1f);
    chk("reset_en", 32'(en_v()), 32'h0);
    chk("reset_pc", 32'(bus.pc_src), 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_halted", 32'(halted), 32'd1);
    chk("post_reset_en", 32'(en_v()), 32'h0);
    chk("post_reset_rst", 32'(rst_v()), 32'h0);
    @(negedge clk);
    chk("run_halted", 32'(halted), 32'd0);
    chk("run_en", 32'(en_v()), 32'h1f);
    chk("run_pc", 32'(bus.pc_src), 32'd0);

    // Vector table while running
    foreach (vecs[i]) begin
      @(posedge clk); #1 apply(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, "_en"},  32'(en_v()),      32'(vecs[i].exp_en));
      chk({vecs[i].name, "_rst"}, 32'(rst_v()),     32'(vecs[i].exp_rst));
      chk({vecs[i].name, "_pc"},  32'(bus.pc_src),  32'(vecs[i].exp_pc));
      chk({vecs[i].name, "_fa"},  32'(bus.fwd_a),   32'(vecs[i].exp_fa));
      chk({vecs[i].name, "_fb"},  32'(bus.fwd_b),   32'(vecs[i].exp_fb));
      chk({vecs[i].name, "_fm"},  32'(bus.fwd_mem), 32'(vecs[i].exp_fm));
      exp_stall += int'(vecs[i].exp_rst[2]);
      exp_flush += int'(vecs[i].exp_rst[3]);
    end
    @(posedge clk); #1 apply(clr("idle"));
    @(negedge clk);
    chk("stall_cnt_after_table", stall_cnt, 32'(exp_stall));
    chk("flush_cnt_after_table", flush_cnt, 32'(exp_flush));

    // Breakpoint at 0x20, then resume from the breakpoint PC
    bp_en = 1'b1; bp_addr = 32'h20;
    @(posedge clk); #1 bus.inst_addr = 32'h1c;
    @(negedge clk);
    chk("bp_pre_halted", 32'(halted), 32'd0);
    @(posedge clk); #1 bus.inst_addr = 32'h20;
    @(negedge clk);
    chk("bp_hit_cycle_en", 32'(en_v()), 32'h1f);
    @(posedge clk); #1 cpu_en = 1'b0; bus.is_jump = 1'b1;
    @(negedge clk);
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_halt_en", 32'(en_v()), 32'h0);
    chk("bp_halt_rst", 32'(rst_v()), 32'h0);
    chk("bp_halt_pc", 32'(bus.pc_src), 32'd0);
    @(posedge clk); #1 cpu_en = 1'b1; bus.is_jump = 1'b0;
    @(negedge clk);
    chk("bp_still_halted", 32'(halted), 32'd1);
    @(negedge clk);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_en", 32'(en_v()), 32'h1f);
    @(posedge clk); #1 bus.inst_addr = 32'h24;
    @(negedge clk);
    chk("resume_no_rehalt", 32'(halted), 32'd0);
    chk("halt_jump_not_counted", flush_cnt, 32'(exp_flush));

    // Single step: step high for 3 cycles gives one active cycle
    @(posedge clk); #1 cpu_en = 1'b0;
    act_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 step = (i < 3);
      @(negedge clk);
      if (bus.wb_en) act_cnt++;
    end
    chk("step_active_cycles", 32'(act_cnt), 32'd1);
    chk("step_halted", 32'(halted), 32'd1);

    // Single step with a pending load stall (and a taken beq)
    st_row = clr("step_stall");
    st_row.el = 1; st_row.ew = 1; st_row.ea = 9; st_row.rs_used = 1; st_row.rs = 9;
    st_row.beq = 1; st_row.eq = 1;
    @(posedge clk); #1 apply(st_row);
    act_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 step = (i < 2);
      @(negedge clk);
      if (bus.wb_en) begin
        act_cnt++;
        chk("step_stall_en", 32'(en_v()), 32'h07);
        chk("step_stall_rst", 32'(rst_v()), 32'h04);
        chk("step_stall_pc", 32'(bus.pc_src), 32'd0);
      end
    end
    exp_stall++;
    chk("step_stall_active_cycles", 32'(act_cnt), 32'd1);
    chk("step_stall_cnt", stall_cnt, 32'(exp_stall));
    chk("step_flush_cnt", flush_cnt, 32'(exp_flush));

    // Reset asserted in the middle of a stall
    @(posedge clk); #1 cpu_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("run_stall_en", 32'(en_v()), 32'h07);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_over_stall_rst", 32'(rst_v()), 32'h1f);
    chk("rst_over_stall_en", 32'(en_v()), 32'h0);
    @(posedge clk); #1 rst = 1'b0; apply(clr("idle"));
    @(negedge clk);
    chk("rst_clear_stall_cnt", stall_cnt, 32'd0);
    chk("rst_clear_flush_cnt", flush_cnt, 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
